mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM port between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_arbiter_pkg.sv | 59 +++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared types, encodings and byte helpers for the byte-wide
//             RAM arbiter between instruction fetch and load/store.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Which requester owns the current transaction
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // mem_len codes (2'b11 is treated as a word)
    localparam logic [1:0]  c_len_byte = 2'b00;
    localparam logic [1:0]  c_len_half = 2'b01;
    localparam logic [1:0]  c_len_word = 2'b10;

    localparam logic [31:0] c_zero32     = 32'h0000_0000;
    localparam logic        c_rst_enable = 1'b1;
    localparam logic        c_stall      = 1'b1;
    localparam logic        c_no_stall   = 1'b0;
    localparam logic [2:0]  c_if_bytes   = 3'd4;

    // Number of byte cycles for a MEM access length code
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            c_len_byte: return 3'd1;
            c_len_half: return 3'd2;
            c_len_word: return 3'd4;
            default:    return 3'd4;
        endcase
    endfunction

    // Extract little-endian byte idx of a word
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    // Replace little-endian byte idx of a word
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one byte-wide synchronous RAM port between instruction
//             fetch (IF) and load/store (MEM). Serialises 1/2/4-byte
//             accesses into byte cycles, little-endian, MEM over IF, and
//             lets a jump flush abort an in-flight fetch.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    input  logic              if_flush_in,
    output logic [31:0]       if_data_out,
    output logic              if_done_out,
    input  logic              mem_req_in,
    input  logic              mem_we_in,
    input  logic [1:0]        mem_len_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    output logic [31:0]       mem_data_out,
    output logic              mem_done_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic              ram_wr_out,
    output logic [7:0]        ram_dout_out,
    input  logic [7:0]        ram_din_in,
    output logic              stallreq_if_out,
    output logic              stallreq_mem_out
);

    // Transaction context latched at accept
    state_t            r_state;
    owner_t            r_owner;
    logic              r_we;
    logic [2:0]        r_nbytes;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    // Number of BUSY edges taken since accept (0 right after accept)
    logic [2:0]        r_cnt;
    // Load bytes gathered so far; upper bytes stay zero for short loads
    logic [31:0]       r_asm;

    // The edge being evaluated is E(r_cnt+1); byte r_cnt+1 gets addressed
    // after it, and byte r_cnt-1 is on ram_din_in at it (2-edge read path).
    logic [2:0]        w_edge_num;
    logic [1:0]        w_cap_idx;
    logic              w_capture;
    logic [31:0]       w_asm_next;
    logic              w_more;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr_next;
    logic [7:0]        w_wbyte;
    logic              w_flush_if;

    assign w_edge_num  = r_cnt + 3'd1;
    assign w_cap_idx   = 2'(r_cnt - 3'd1);
    assign w_capture   = ~r_we && (r_cnt != 3'd0) && (r_cnt <= r_nbytes);
    assign w_asm_next  = w_capture ? put_byte(r_asm, w_cap_idx, ram_din_in) : r_asm;
    assign w_more      = (w_edge_num < r_nbytes);
    assign w_last      = r_we ? (w_edge_num == r_nbytes) : (w_edge_num == (r_nbytes + 3'd1));
    assign w_addr_next = r_base + ADDR_W'(w_edge_num);
    assign w_wbyte     = get_byte(r_wdata, w_edge_num[1:0]);
    assign w_flush_if  = (r_owner == OWN_IF) && if_flush_in;

    // Stall requests go straight to the stall controller, so they are combinational
    assign stallreq_if_out  = (if_req_in & ~if_done_out & ~if_flush_in) ? c_stall : c_no_stall;
    assign stallreq_mem_out = (mem_req_in & ~mem_done_out) ? c_stall : c_no_stall;

    // Arbitration FSM with registered RAM port and requester outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == c_rst_enable) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_we         <= 1'b0;
            r_nbytes     <= 3'd0;
            r_base       <= '0;
            r_wdata      <= c_zero32;
            r_cnt        <= 3'd0;
            r_asm        <= c_zero32;
            if_data_out  <= c_zero32;
            if_done_out  <= 1'b0;
            mem_data_out <= c_zero32;
            mem_done_out <= 1'b0;
            ram_addr_out <= '0;
            ram_wr_out   <= 1'b0;
            ram_dout_out <= 8'h00;
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_req_in) begin
                        r_state      <= ST_BUSY;
                        r_owner      <= OWN_MEM;
                        r_we         <= mem_we_in;
                        r_nbytes     <= len_to_bytes(mem_len_in);
                        r_base       <= mem_addr_in;
                        r_wdata      <= mem_wdata_in;
                        r_cnt        <= 3'd0;
                        r_asm        <= c_zero32;
                        ram_addr_out <= mem_addr_in;
                        ram_wr_out   <= mem_we_in;
                        ram_dout_out <= mem_wdata_in[7:0];
                    end else if (if_req_in && !if_flush_in) begin
                        r_state      <= ST_BUSY;
                        r_owner      <= OWN_IF;
                        r_we         <= 1'b0;
                        r_nbytes     <= c_if_bytes;
                        r_base       <= if_addr_in;
                        r_wdata      <= c_zero32;
                        r_cnt        <= 3'd0;
                        r_asm        <= c_zero32;
                        ram_addr_out <= if_addr_in;
                        ram_wr_out   <= 1'b0;
                        ram_dout_out <= 8'h00;
                    end
                end
                ST_BUSY: begin
                    if (w_flush_if) begin
                        // Fetch is read-only, so abandoning it leaves RAM untouched
                        r_state    <= ST_IDLE;
                        ram_wr_out <= 1'b0;
                    end else begin
                        r_cnt <= w_edge_num;
                        r_asm <= w_asm_next;
                        if (w_more) begin
                            ram_addr_out <= w_addr_next;
                            ram_dout_out <= w_wbyte;
                        end
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            ram_wr_out <= 1'b0;
                            // Stores leave the owner's data output untouched
                            if (r_owner == OWN_IF) begin
                                if_done_out <= 1'b1;
                                if (!r_we) if_data_out <= w_asm_next;
                            end else begin
                                mem_done_out <= 1'b1;
                                if (!r_we) mem_data_out <= w_asm_next;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    if_done_out  <= 1'b0;
                    mem_done_out <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter with a
//             byte-wide synchronous RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_flush_in;
    logic [31:0] if_data_out;
    logic        if_done_out;
    logic        mem_req_in;
    logic        mem_we_in;
    logic [1:0]  mem_len_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic [31:0] mem_data_out;
    logic        mem_done_out;
    logic [31:0] ram_addr_out;
    logic        ram_wr_out;
    logic [7:0]  ram_dout_out;
    logic [7:0]  ram_din_in = 8'h00;
    logic        stallreq_if_out;
    logic        stallreq_mem_out;

    logic [7:0]  ram [0:65535];

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .if_req_in       (if_req_in),
        .if_addr_in      (if_addr_in),
        .if_flush_in     (if_flush_in),
        .if_data_out     (if_data_out),
        .if_done_out     (if_done_out),
        .mem_req_in      (mem_req_in),
        .mem_we_in       (mem_we_in),
        .mem_len_in      (mem_len_in),
        .mem_addr_in     (mem_addr_in),
        .mem_wdata_in    (mem_wdata_in),
        .mem_data_out    (mem_data_out),
        .mem_done_out    (mem_done_out),
        .ram_addr_out    (ram_addr_out),
        .ram_wr_out      (ram_wr_out),
        .ram_dout_out    (ram_dout_out),
        .ram_din_in      (ram_din_in),
        .stallreq_if_out (stallreq_if_out),
        .stallreq_mem_out(stallreq_mem_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous read-first RAM, paused together with the arbiter
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (ram_wr_out) ram[ram_addr_out[15:0]] <= ram_dout_out;
            ram_din_in <= ram[ram_addr_out[15:0]];
        end
    end

    // Waits (bounded) for a done pulse; n = negedges until seen, -1 on timeout
    task automatic wait_done(input bit want_if, input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk_in);
            if ((want_if ? if_done_out : mem_done_out) === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        if_req_in = 1'b0; if_addr_in = 32'h0; if_flush_in = 1'b0;
        mem_req_in = 1'b0; mem_we_in = 1'b0; mem_len_in = 2'b00;
        mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
        repeat (2) @(negedge clk_in);
        checks++; if (if_done_out !== 1'b0) begin failures++; $display("FAIL reset_if_done: got %b expected 0", if_done_out); end
        checks++; if (mem_done_out !== 1'b0) begin failures++; $display("FAIL reset_mem_done: got %b expected 0", mem_done_out); end
        checks++; if (ram_wr_out !== 1'b0) begin failures++; $display("FAIL reset_ram_wr: got %b expected 0", ram_wr_out); end
        checks++; if (ram_addr_out !== 32'h0) begin failures++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr_out); end
        checks++; if (ram_dout_out !== 8'h0) begin failures++; $display("FAIL reset_ram_dout: got %h expected 0", ram_dout_out); end
        checks++; if (if_data_out !== 32'h0) begin failures++; $display("FAIL reset_if_data: got %h expected 0", if_data_out); end
        checks++; if (mem_data_out !== 32'h0) begin failures++; $display("FAIL reset_mem_data: got %h expected 0", mem_data_out); end
        checks++; if (stallreq_if_out !== 1'b0 || stallreq_mem_out !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b%b expected 00", stallreq_if_out, stallreq_mem_out); end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_fetch();
        int n;
        ram[16'h1000] = 8'h11; ram[16'h1001] = 8'h22; ram[16'h1002] = 8'h33; ram[16'h1003] = 8'h44;
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        #1;
        checks++; if (stallreq_if_out !== 1'b1) begin failures++; $display("FAIL fetch_stall_start: got %b expected 1", stallreq_if_out); end
        n = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            if (k <= 4) begin
                checks++;
                if (ram_addr_out !== (32'h1000 + 32'(k) - 32'd1)) begin
                    failures++; $display("FAIL fetch_addr: got %h expected %h", ram_addr_out, 32'h1000 + 32'(k) - 32'd1);
                end
            end
            if (if_done_out === 1'b1) begin n = k; break; end
            checks++; if (stallreq_if_out !== 1'b1) begin failures++; $display("FAIL fetch_stall_busy: got %b expected 1", stallreq_if_out); end
        end
        checks++; if (n !== 6) begin failures++; $display("FAIL fetch_latency: got %0d expected 6", n); end
        checks++; if (if_data_out !== 32'h4433_2211) begin failures++; $display("FAIL fetch_data: got %h expected 44332211", if_data_out); end
        checks++; if (stallreq_if_out !== 1'b0) begin failures++; $display("FAIL fetch_stall_done: got %b expected 0", stallreq_if_out); end
        if_req_in = 1'b0;
        @(negedge clk_in);
        checks++; if (if_done_out !== 1'b0) begin failures++; $display("FAIL fetch_done_pulse: got %b expected 0", if_done_out); end
        checks++; if (if_data_out !== 32'h4433_2211) begin failures++; $display("FAIL fetch_data_hold: got %h expected 44332211", if_data_out); end
    endtask

    task automatic test_priority();
        int n, nw;
        logic [31:0] wd;
        wd = 32'hDEAD_BEEF;
        ram[16'h20] = 8'h00; ram[16'h21] = 8'h00; ram[16'h22] = 8'h00; ram[16'h23] = 8'h00;
        repeat (2) @(negedge clk_in);
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 2'b10;
        mem_addr_in = 32'h20; mem_wdata_in = wd;
        if_req_in = 1'b1; if_addr_in = 32'h20;
        n = -1; nw = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            if (ram_wr_out === 1'b1) begin
                nw++;
                checks++;
                if (ram_addr_out !== (32'h20 + 32'(nw) - 32'd1) || ram_dout_out !== wd[8*(nw-1) +: 8]) begin
                    failures++; $display("FAIL store_byte%0d: got %h@%h expected %h@%h", nw - 1, ram_dout_out, ram_addr_out, wd[8*(nw-1) +: 8], 32'h20 + 32'(nw) - 32'd1);
                end
            end
            if (mem_done_out === 1'b1) begin n = k; break; end
        end
        checks++; if (nw !== 4) begin failures++; $display("FAIL store_write_count: got %0d expected 4", nw); end
        checks++; if (n !== 5) begin failures++; $display("FAIL store_latency: got %0d expected 5", n); end
        checks++; if (if_done_out !== 1'b0 || stallreq_if_out !== 1'b1) begin failures++; $display("FAIL prio_if_waiting: got done=%b stall=%b expected done=0 stall=1", if_done_out, stallreq_if_out); end
        mem_req_in = 1'b0; mem_we_in = 1'b0;
        wait_done(1'b1, 15, n);
        checks++; if (n !== 7) begin failures++; $display("FAIL prio_if_latency: got %0d expected 7", n); end
        checks++; if (if_data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL prio_if_data: got %h expected deadbeef", if_data_out); end
        if_req_in = 1'b0;
    endtask

    task automatic test_loads();
        int n;
        ram[16'h0003] = 8'h80;
        repeat (2) @(negedge clk_in);
        mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 2'b00; mem_addr_in = 32'h3;
        wait_done(1'b0, 12, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL lb_latency: got %0d expected 3", n); end
        checks++; if (mem_data_out !== 32'h0000_0080) begin failures++; $display("FAIL lb_data: got %h expected 00000080", mem_data_out); end
        mem_req_in = 1'b0;
        // half load straddling the top of the address space
        ram[16'hFFFF] = 8'h5A; ram[16'h0000] = 8'hA5;
        repeat (2) @(negedge clk_in);
        mem_req_in = 1'b1; mem_len_in = 2'b01; mem_addr_in = 32'hFFFF_FFFF;
        @(negedge clk_in);
        checks++; if (ram_addr_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lh_addr0: got %h expected ffffffff", ram_addr_out); end
        @(negedge clk_in);
        checks++; if (ram_addr_out !== 32'h0) begin failures++; $display("FAIL lh_addr_wrap: got %h expected 00000000", ram_addr_out); end
        wait_done(1'b0, 12, n);
        checks++; if (n + 2 !== 4) begin failures++; $display("FAIL lh_latency: got %0d expected 4", n + 2); end
        checks++; if (mem_data_out !== 32'h0000_A55A) begin failures++; $display("FAIL lh_data: got %h expected 0000a55a", mem_data_out); end
        mem_req_in = 1'b0;
        // byte store touches exactly one byte
        ram[16'h50] = 8'h00; ram[16'h51] = 8'h33;
        repeat (2) @(negedge clk_in);
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 2'b00;
        mem_addr_in = 32'h50; mem_wdata_in = 32'h1234_5677;
        wait_done(1'b0, 12, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL sb_latency: got %0d expected 2", n); end
        checks++; if (ram[16'h50] !== 8'h77 || ram[16'h51] !== 8'h33) begin failures++; $display("FAIL sb_ram: got %h %h expected 77 33", ram[16'h50], ram[16'h51]); end
        mem_req_in = 1'b0; mem_we_in = 1'b0;
    endtask

    task automatic test_flush();
        int n;
        ram[16'h0200] = 8'h01; ram[16'h0201] = 8'h02; ram[16'h0202] = 8'h03; ram[16'h0203] = 8'h04;
        repeat (2) @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'h100;
        repeat (3) @(negedge clk_in);
        checks++; if (ram_addr_out !== 32'h102) begin failures++; $display("FAIL flush_byte2_addr: got %h expected 00000102", ram_addr_out); end
        if_flush_in = 1'b1; if_addr_in = 32'h200;
        #1;
        checks++; if (stallreq_if_out !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", stallreq_if_out); end
        @(negedge clk_in);
        checks++; if (if_done_out !== 1'b0 || ram_wr_out !== 1'b0 || ram_addr_out !== 32'h102) begin failures++; $display("FAIL flush_abort: got done=%b wr=%b addr=%h expected 0 0 00000102", if_done_out, ram_wr_out, ram_addr_out); end
        @(negedge clk_in);
        checks++; if (if_done_out !== 1'b0 || ram_addr_out !== 32'h102) begin failures++; $display("FAIL flush_hold_idle: got done=%b addr=%h expected 0 00000102", if_done_out, ram_addr_out); end
        if_flush_in = 1'b0;
        @(negedge clk_in);
        checks++; if (ram_addr_out !== 32'h200) begin failures++; $display("FAIL flush_target_accept: got %h expected 00000200", ram_addr_out); end
        wait_done(1'b1, 12, n);
        checks++; if (n + 1 !== 6) begin failures++; $display("FAIL flush_target_latency: got %0d expected 6", n + 1); end
        checks++; if (if_data_out !== 32'h0403_0201) begin failures++; $display("FAIL flush_target_data: got %h expected 04030201", if_data_out); end
        if_req_in = 1'b0;
    endtask

    task automatic test_rdy();
        int n;
        ram[16'h0300] = 8'hA1; ram[16'h0301] = 8'hB2; ram[16'h0302] = 8'hC3; ram[16'h0303] = 8'hD4;
        repeat (2) @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'h300;
        repeat (2) @(negedge clk_in);
        checks++; if (ram_addr_out !== 32'h301) begin failures++; $display("FAIL rdy_addr_before: got %h expected 00000301", ram_addr_out); end
        rdy_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++; if (ram_addr_out !== 32'h301 || if_done_out !== 1'b0) begin failures++; $display("FAIL rdy_frozen: got addr=%h done=%b expected 00000301 0", ram_addr_out, if_done_out); end
        rdy_in = 1'b1;
        wait_done(1'b1, 12, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL rdy_latency: got %0d expected 4 after resume", n); end
        checks++; if (if_data_out !== 32'hD4C3_B2A1) begin failures++; $display("FAIL rdy_data: got %h expected d4c3b2a1", if_data_out); end
        if_req_in = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        ram[16'h0400] = 8'h00; ram[16'h0401] = 8'h00; ram[16'h0402] = 8'h00; ram[16'h0403] = 8'h00;
        repeat (2) @(negedge clk_in);
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 2'b10;
        mem_addr_in = 32'h400; mem_wdata_in = 32'h4433_2211;
        repeat (2) @(negedge clk_in);
        checks++; if (ram_wr_out !== 1'b1 || ram_addr_out !== 32'h401) begin failures++; $display("FAIL arst_pre: got wr=%b addr=%h expected 1 00000401", ram_wr_out, ram_addr_out); end
        #2 rst_in = 1'b1;
        #1;
        checks++; if (ram_wr_out !== 1'b0 || ram_addr_out !== 32'h0) begin failures++; $display("FAIL arst_immediate: got wr=%b addr=%h expected 0 00000000", ram_wr_out, ram_addr_out); end
        mem_req_in = 1'b0; mem_we_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        checks++; if (ram[16'h0400] !== 8'h11 || ram[16'h0401] !== 8'h00) begin failures++; $display("FAIL arst_ram: got %h %h expected 11 00", ram[16'h0400], ram[16'h0401]); end
        checks++; if (mem_data_out !== 32'h0) begin failures++; $display("FAIL arst_mem_data: got %h expected 0", mem_data_out); end
        mem_req_in = 1'b1; mem_len_in = 2'b00; mem_addr_in = 32'h400;
        wait_done(1'b0, 12, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL arst_idle_latency: got %0d expected 3", n); end
        checks++; if (mem_data_out !== 32'h0000_0011) begin failures++; $display("FAIL arst_load_data: got %h expected 00000011", mem_data_out); end
        mem_req_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_loads();
        test_flush();
        test_rdy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
